// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse link: default width, FSM and shift-register mode encodings.
package pulse_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned ErrCntW      = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StTrack   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SrHold   = 2'b00,
        SrShift  = 2'b01,
        SrRotate = 2'b10,
        SrLoad   = 2'b11
    } sr_mode_e;

    function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
        return (v == {ErrCntW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pulse_shift_reg.sv
// Width-bit register with hold, serial shift-in (at LSB), rotate-left and parallel load.
module pulse_shift_reg
    import pulse_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  sr_mode_e         mode_i,
    input  logic             ser_i,
    input  logic [Width-1:0] load_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        unique case (mode_i)
            SrHold:   q_d = q_q;
            SrShift:  q_d = {q_q[Width-2:0], ser_i};
            SrRotate: q_d = {q_q[Width-2:0], q_q[Width-1]};
            SrLoad:   q_d = load_i;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pulse_receiver.sv
// Serial receiver: captures one WIDTH-bit period, then tracks the circular stream and
// drops lock after ERR_LIMIT consecutive mismatches.
module pulse_receiver
    import pulse_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               serial_in,
    input  logic               start_flag,
    output logic [WIDTH-1:0]   word_out,
    output logic               word_valid,
    output logic               locked,
    output logic               error_pulse,
    output logic [ErrCntW-1:0] err_count
);

    localparam int unsigned CntW  = $clog2(WIDTH);
    localparam int unsigned ConsW = $clog2(ERR_LIMIT + 1);
    localparam logic [CntW-1:0]  LastBit   = CntW'(WIDTH - 1);
    localparam logic [ConsW-1:0] ConsLimit = ConsW'(ERR_LIMIT);

    state_e             state_d, state_q;
    logic [CntW-1:0]    bit_cnt_d, bit_cnt_q;
    logic [ConsW-1:0]   consec_d, consec_q, consec_inc;
    logic [ErrCntW-1:0] err_cnt_d, err_cnt_q;
    logic [WIDTH-1:0]   word_d, word_q;
    logic               valid_d, valid_q;
    logic               locked_d, locked_q;
    logic               errp_d, errp_q;

    sr_mode_e           shreg_mode, exp_mode;
    logic [WIDTH-1:0]   shreg_q, exp_q, assembled;
    logic               mismatch;

    pulse_shift_reg #(.Width(WIDTH)) u_shreg (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .mode_i (shreg_mode),
        .ser_i  (serial_in),
        .load_i ('0),
        .q_o    (shreg_q)
    );

    pulse_shift_reg #(.Width(WIDTH)) u_exp (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .mode_i (exp_mode),
        .ser_i  (1'b0),
        .load_i (assembled),
        .q_o    (exp_q)
    );

    // Word including the bit sampled on this edge.
    assign assembled  = {shreg_q[WIDTH-2:0], serial_in};
    assign mismatch   = (serial_in != exp_q[WIDTH-1]);
    assign consec_inc = consec_q + ConsW'(1);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        consec_d   = consec_q;
        err_cnt_d  = err_cnt_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        errp_d     = 1'b0;
        shreg_mode = SrHold;
        exp_mode   = SrHold;

        if (start_flag) begin
            shreg_mode = SrShift;
            bit_cnt_d  = CntW'(1);
            err_cnt_d  = '0;
            consec_d   = '0;
            locked_d   = 1'b0;
            state_d    = StCapture;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCapture: begin
                    shreg_mode = SrShift;
                    if (bit_cnt_q == LastBit) begin
                        word_d    = assembled;
                        exp_mode  = SrLoad;
                        valid_d   = 1'b1;
                        locked_d  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = StTrack;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
                StTrack: begin
                    exp_mode  = SrRotate;
                    bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + CntW'(1);
                    if (mismatch) begin
                        errp_d    = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                        consec_d  = consec_inc;
                    end else begin
                        consec_d  = '0;
                    end
                    if (mismatch && (consec_inc == ConsLimit)) begin
                        locked_d = 1'b0;
                        consec_d = '0;
                        state_d  = StIdle;
                    end else if (bit_cnt_q == LastBit) begin
                        valid_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            consec_q  <= '0;
            err_cnt_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            errp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            consec_q  <= consec_d;
            err_cnt_q <= err_cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            errp_q    <= errp_d;
        end
    end

    assign word_out    = word_q;
    assign word_valid  = valid_q;
    assign locked      = locked_q;
    assign error_pulse = errp_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver: the bench plays the generator's role, driving the pattern MSB first.
module tb_pulse_receiver;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        serial_in = 1'b0;
    logic        start_flag = 1'b0;
    logic [15:0] word_out;
    logic        word_valid;
    logic        locked;
    logic        error_pulse;
    logic [7:0]  err_count;

    int passed = 0;
    int total  = 0;

    logic [15:0] pat = 16'h0000;
    int          idx = 15;

    pulse_receiver #(.WIDTH(16), .ERR_LIMIT(3)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .start_flag  (start_flag),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .locked      (locked),
        .error_pulse (error_pulse),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    task automatic send(input logic b, input logic st);
        serial_in  = b;
        start_flag = st;
        @(posedge clock);
        #1;
        start_flag = 1'b0;
    endtask

    task automatic send_pat(input logic inv, input logic st);
        send(pat[idx] ^ inv, st);
        idx = (idx == 0) ? 15 : idx - 1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) send(1'b1, 1'b0);
        total++;
        if ({word_out, word_valid, locked, error_pulse, err_count} !== 27'd0) begin
            $display("FAIL reset_outputs: got wo=%h wv=%b lk=%b ep=%b ec=%0d want all 0",
                     word_out, word_valid, locked, error_pulse, err_count);
        end else passed++;
        reset_n = 1'b1;
        repeat (20) send(1'b1, 1'b0);
        total++;
        if (locked !== 1'b0 || word_valid !== 1'b0 || word_out !== 16'h0) begin
            $display("FAIL reset_idle: got lk=%b wv=%b wo=%h want 0 0 0000", locked, word_valid,
                     word_out);
        end else passed++;
    endtask

    task automatic test_capture(input logic [15:0] p, input logic [15:0] prev_word);
        int early = 0;
        pat = p;
        idx = 15;
        send_pat(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            send_pat(1'b0, 1'b0);
            if (word_valid !== 1'b0 || word_out !== prev_word) early++;
        end
        total++;
        if (early != 0) $display("FAIL capture_early: got %0d early updates want 0", early);
        else passed++;
        send_pat(1'b0, 1'b0);
        total++;
        if (word_valid !== 1'b1 || word_out !== p || locked !== 1'b1) begin
            $display("FAIL capture_done: got wv=%b wo=%h lk=%b want 1 %h 1", word_valid, word_out,
                     locked, p);
        end else passed++;
        send_pat(1'b0, 1'b0);
        total++;
        if (word_valid !== 1'b0) $display("FAIL capture_pulse: got wv=%b want 0", word_valid);
        else passed++;
    endtask

    task automatic test_tracking;
        int wv_cnt = 0;
        int ep_cnt = 0;
        int misplaced = 0;
        int sent;
        for (int i = 0; i < 64; i++) begin
            sent = idx;
            send_pat(1'b0, 1'b0);
            if (word_valid === 1'b1) wv_cnt++;
            if (error_pulse === 1'b1) ep_cnt++;
            if (word_valid !== (sent == 0)) misplaced++;
        end
        total++;
        if (wv_cnt != 4 || misplaced != 0) begin
            $display("FAIL track_valid: got %0d pulses, %0d misplaced want 4, 0", wv_cnt, misplaced);
        end else passed++;
        total++;
        if (ep_cnt != 0 || err_count !== 8'd0 || locked !== 1'b1) begin
            $display("FAIL track_clean: got ep=%0d ec=%0d lk=%b want 0 0 1", ep_cnt, err_count,
                     locked);
        end else passed++;
    endtask

    task automatic test_single_error;
        send_pat(1'b1, 1'b0);
        total++;
        if (error_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1) begin
            $display("FAIL single_err: got ep=%b ec=%0d lk=%b want 1 1 1", error_pulse, err_count,
                     locked);
        end else passed++;
        send_pat(1'b0, 1'b0);
        total++;
        if (error_pulse !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1) begin
            $display("FAIL single_after: got ep=%b ec=%0d lk=%b want 0 1 1", error_pulse, err_count,
                     locked);
        end else passed++;
    endtask

    task automatic test_loss_of_lock;
        int ep_cnt = 0;
        int lk_early = 0;
        for (int i = 0; i < 3; i++) begin
            send_pat(1'b1, 1'b0);
            if (error_pulse === 1'b1) ep_cnt++;
            if (i < 2 && locked !== 1'b1) lk_early++;
        end
        total++;
        if (ep_cnt != 3 || lk_early != 0) begin
            $display("FAIL lol_pulses: got ep=%0d early_unlock=%0d want 3 0", ep_cnt, lk_early);
        end else passed++;
        total++;
        if (locked !== 1'b0 || err_count !== 8'd4 || word_out !== 16'hA5C3) begin
            $display("FAIL lol_state: got lk=%b ec=%0d wo=%h want 0 4 a5c3", locked, err_count,
                     word_out);
        end else passed++;
        ep_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send_pat(1'b1, 1'b0);
            if (error_pulse !== 1'b0 || word_valid !== 1'b0 || locked !== 1'b0) ep_cnt++;
        end
        total++;
        if (ep_cnt != 0 || err_count !== 8'd4 || word_out !== 16'hA5C3) begin
            $display("FAIL lol_idle: got %0d active cycles ec=%0d wo=%h want 0 4 a5c3", ep_cnt,
                     err_count, word_out);
        end else passed++;
    endtask

    task automatic test_restart;
        test_capture(16'hA5C3, 16'hA5C3);
        repeat (4) send_pat(1'b0, 1'b0);
        send_pat(1'b1, 1'b0);
        pat = 16'h0F0F;
        idx = 15;
        send_pat(1'b0, 1'b1);
        total++;
        if (locked !== 1'b0 || err_count !== 8'd0 || word_out !== 16'hA5C3) begin
            $display("FAIL restart_start: got lk=%b ec=%0d wo=%h want 0 0 a5c3", locked, err_count,
                     word_out);
        end else passed++;
        repeat (14) send_pat(1'b0, 1'b0);
        total++;
        if (word_out !== 16'hA5C3 || word_valid !== 1'b0) begin
            $display("FAIL restart_partial: got wo=%h wv=%b want a5c3 0", word_out, word_valid);
        end else passed++;
        send_pat(1'b0, 1'b0);
        total++;
        if (word_out !== 16'h0F0F || word_valid !== 1'b1 || locked !== 1'b1) begin
            $display("FAIL restart_done: got wo=%h wv=%b lk=%b want 0f0f 1 1", word_out, word_valid,
                     locked);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        // start on the completing capture edge wins over completion
        pat = 16'h1234;
        idx = 15;
        send_pat(1'b0, 1'b1);
        repeat (14) send_pat(1'b0, 1'b0);
        pat = 16'h00FF;
        idx = 15;
        send_pat(1'b0, 1'b1);
        total++;
        if (word_valid !== 1'b0 || word_out !== 16'h0F0F || locked !== 1'b0) begin
            $display("FAIL prio_capture: got wv=%b wo=%h lk=%b want 0 0f0f 0", word_valid, word_out,
                     locked);
        end else passed++;
        repeat (15) send_pat(1'b0, 1'b0);
        total++;
        if (word_out !== 16'h00FF || word_valid !== 1'b1) begin
            $display("FAIL prio_recapture: got wo=%h wv=%b want 00ff 1", word_out, word_valid);
        end else passed++;
        // two mismatches, then start on a third mismatching bit
        send_pat(1'b1, 1'b0);
        send_pat(1'b1, 1'b0);
        pat = 16'hBC3C;
        idx = 15;
        send_pat(1'b0, 1'b1);
        total++;
        if (error_pulse !== 1'b0 || err_count !== 8'd0 || locked !== 1'b0) begin
            $display("FAIL prio_errexit: got ep=%b ec=%0d lk=%b want 0 0 0", error_pulse, err_count,
                     locked);
        end else passed++;
        repeat (15) send_pat(1'b0, 1'b0);
        total++;
        if (word_out !== 16'hBC3C || locked !== 1'b1) begin
            $display("FAIL prio_bc3c: got wo=%h lk=%b want bc3c 1", word_out, locked);
        end else passed++;
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 512; i++) send_pat((i % 2) == 0, 1'b0);
        total++;
        if (err_count !== 8'd255 || locked !== 1'b1) begin
            $display("FAIL saturate: got ec=%0d lk=%b want 255 1", err_count, locked);
        end else passed++;
    endtask

    task automatic test_reset_mid;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({word_out, word_valid, locked, error_pulse, err_count} !== 27'd0) begin
            $display("FAIL reset_track: got wo=%h lk=%b ec=%0d want 0000 0 0", word_out, locked,
                     err_count);
        end else passed++;
        @(posedge clock);
        #1 reset_n = 1'b1;
        pat = 16'hA5C3;
        idx = 15;
        send_pat(1'b0, 1'b1);
        repeat (7) send_pat(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (9) send_pat(1'b0, 1'b0);
        total++;
        if (word_out !== 16'h0 || word_valid !== 1'b0 || locked !== 1'b0) begin
            $display("FAIL reset_capture: got wo=%h wv=%b lk=%b want 0000 0 0", word_out,
                     word_valid, locked);
        end else passed++;
    endtask

    initial begin
        test_reset;
        test_capture(16'hA5C3, 16'h0000);
        test_tracking;
        test_single_error;
        test_loss_of_lock;
        test_restart;
        test_back_to_back;
        test_saturation;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
